// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, Nk/Nr decode, Rcon table,
// key-schedule FSM states and the default round-key store depth.
package aes_pkg;

  localparam int AES_MAX_WORDS = 60;

  localparam logic [1:0] KEYLEN_128  = 2'b00;
  localparam logic [1:0] KEYLEN_192  = 2'b01;
  localparam logic [1:0] KEYLEN_256  = 2'b10;
  localparam logic [1:0] KEYLEN_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_DONE
  } ks_state_e;

  typedef struct packed {
    logic [3:0] nk;
    logic [3:0] nr;
  } key_cfg_t;

  // Reserved encoding decodes like AES-128; callers reject it before use.
  function automatic key_cfg_t key_cfg(input logic [1:0] key_len);
    key_cfg_t cfg;
    case (key_len)
      KEYLEN_192: begin cfg.nk = 4'd6; cfg.nr = 4'd12; end
      KEYLEN_256: begin cfg.nk = 4'd8; cfg.nr = 4'd14; end
      default:    begin cfg.nk = 4'd4; cfg.nr = 4'd10; end
    endcase
    return cfg;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (one byte), shared with the cipher datapath.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128/192/256 key expansion, one schedule word per clock.
// Define KEYSCHED_RDPORT_EN to add the registered rk_idx/rk_out round-key read port.
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int MAX_WORDS = AES_MAX_WORDS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             key_len,
  input  logic [255:0]           key_in,
`ifdef KEYSCHED_RDPORT_EN
  input  logic [3:0]             rk_idx,
  output logic [127:0]           rk_out,
`endif
  output logic                   busy,
  output logic                   valid,
  output logic                   err,
  output logic [32*MAX_WORDS-1:0] all_keys
);

  localparam int IW = $clog2(MAX_WORDS);

  ks_state_e      state_q, state_d;
  logic [255:0]   key_q, key_d;
  logic [3:0]     nk_q, nk_d;
  logic [3:0]     nr_q, nr_d;
  logic [3:0]     idx_q, idx_d;
  logic [2:0]     m_q, m_d;
  logic [IW-1:0]  i_q, i_d;
  logic [IW-1:0]  last_q, last_d;
  logic           err_q, err_d;
  logic [31:0]    store_q [MAX_WORDS];
  logic [31:0]    store_d [MAX_WORDS];

  key_cfg_t       cfg;
  logic [31:0]    prev_w, back_w, sub_in, sub_out, temp_w;

  assign cfg    = key_cfg(key_len);
  assign prev_w = store_q[i_q - IW'(1)];
  assign back_w = store_q[i_q - IW'(nk_q)];
  assign sub_in = (m_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .in_i  (sub_in[8*b +: 8]),
      .out_o (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    temp_w = prev_w;
    if (m_q == 3'd0) begin
      temp_w = sub_out ^ {rcon(idx_q), 24'h0};
    end else if (nk_q == 4'd8 && m_q == 3'd4) begin
      temp_w = sub_out;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    nk_d    = nk_q;
    nr_d    = nr_q;
    idx_d   = idx_q;
    m_d     = m_q;
    i_d     = i_q;
    last_d  = last_q;
    err_d   = 1'b0;
    store_d = store_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (key_len == KEYLEN_RSVD) begin
            err_d = 1'b1;
          end else begin
            key_d   = key_in;
            nk_d    = cfg.nk;
            nr_d    = cfg.nr;
            last_d  = IW'({cfg.nr, 2'b11});
            for (int k = 0; k < MAX_WORDS; k++) store_d[k] = '0;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        for (int k = 0; k < 8; k++) begin
          if (k < int'(nk_q)) store_d[k] = key_q[255-32*k -: 32];
        end
        i_d     = IW'(nk_q);
        m_d     = 3'd0;
        idx_d   = 4'd1;
        state_d = ST_EXPAND;
      end
      ST_EXPAND: begin
        store_d[i_q] = back_w ^ temp_w;
        // m wraps at Nk; idx only advances on the RotWord/Rcon words
        if ({1'b0, m_q} == nk_q - 4'd1) m_d = 3'd0;
        else                            m_d = m_q + 3'd1;
        if (m_q == 3'd0) idx_d = idx_q + 4'd1;
        i_d = i_q + IW'(1);
        if (i_q == last_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      nk_q    <= '0;
      nr_q    <= '0;
      idx_q   <= '0;
      m_q     <= '0;
      i_q     <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < MAX_WORDS; k++) store_q[k] <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      nk_q    <= nk_d;
      nr_q    <= nr_d;
      idx_q   <= idx_d;
      m_q     <= m_d;
      i_q     <= i_d;
      last_q  <= last_d;
      err_q   <= err_d;
      store_q <= store_d;
    end
  end

  assign busy  = (state_q == ST_LOAD) || (state_q == ST_EXPAND);
  assign valid = (state_q == ST_DONE);
  assign err   = err_q;

  always_comb begin
    all_keys = '0;
    for (int k = 0; k < MAX_WORDS; k++) all_keys[32*(MAX_WORDS-1-k) +: 32] = store_q[k];
  end

`ifdef KEYSCHED_RDPORT_EN
  logic [127:0]  rk_q, rk_d;
  logic [IW-1:0] rk_base;

  always_comb begin
    rk_base = IW'({rk_idx, 2'b00});
    rk_d    = '0;
    if (rk_idx <= nr_q) begin
      rk_d = {store_q[rk_base], store_q[rk_base + IW'(1)],
              store_q[rk_base + IW'(2)], store_q[rk_base + IW'(3)]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rk_q <= '0;
    else       rk_q <= rk_d;
  end

  assign rk_out = rk_q;
`endif

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Self-checking bench for aes_key_schedule_seq against a FIPS-197 style reference model.
module tb_aes_key_schedule_seq;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [1:0]     keyLen;
  logic [255:0]   keyIn;
  logic           busy, valid, err;
  logic [1919:0]  allKeys;
`ifdef KEYSCHED_RDPORT_EN
  logic [3:0]     rkIdx;
  logic [127:0]   rkOut;
`endif

  int             errors = 0;
  int             checks = 0;
  logic [7:0]     tbSbox [256];
  logic [31:0]    expWords [60];

  always #5 clk = ~clk;

  aes_key_schedule_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key_len  (keyLen),
    .key_in   (keyIn),
`ifdef KEYSCHED_RDPORT_EN
    .rk_idx   (rkIdx),
    .rk_out   (rkOut),
`endif
    .busy     (busy),
    .valid    (valid),
    .err      (err),
    .all_keys (allKeys)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box derived from the GF(2^8) inverse and affine map, independent of the RTL table
  task automatic buildSbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gfMul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      tbSbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {tbSbox[w[31:24]], tbSbox[w[23:16]], tbSbox[w[15:8]], tbSbox[w[7:0]]};
  endfunction

  function automatic int nkOf(input logic [1:0] kl);
    return (kl == 2'b00) ? 4 : (kl == 2'b01) ? 6 : 8;
  endfunction

  function automatic int latencyOf(input logic [1:0] kl);
    return 1 + 4 * (nkOf(kl) + 7) - nkOf(kl);
  endfunction

  task automatic modelExpand(input logic [1:0] kl, input logic [255:0] key);
    int nk, total;
    logic [31:0] temp;
    logic [7:0] rc;
    nk = nkOf(kl);
    total = 4 * (nk + 7);
    for (int k = 0; k < 60; k++) expWords[k] = 32'h0;
    for (int k = 0; k < nk; k++) expWords[k] = key[255-32*k -: 32];
    for (int k = nk; k < total; k++) begin
      temp = expWords[k-1];
      if (k % nk == 0) begin
        rc = 8'h01;
        for (int r = 1; r < k / nk; r++) rc = xtime(rc);
        temp = subWord({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
      end else if (nk > 6 && k % nk == 4) begin
        temp = subWord(temp);
      end
      expWords[k] = expWords[k-nk] ^ temp;
    end
  endtask

  function automatic logic [31:0] dutWord(input int k);
    return allKeys[1919-32*k -: 32];
  endfunction

  function automatic logic [127:0] dutRoundKey(input int r);
    return {dutWord(4*r), dutWord(4*r+1), dutWord(4*r+2), dutWord(4*r+3)};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic checkStore(input string tag);
    for (int k = 0; k < 60; k++) begin
      checkOutput($sformatf("%s_w%0d", tag, k), 128'(dutWord(k)), 128'(expWords[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle; returns 1 time unit after the sampling edge
  task automatic applyStimulus(input logic [1:0] kl, input logic [255:0] key);
    start  = 1'b1;
    keyLen = kl;
    keyIn  = key;
    tick();
    start  = 1'b0;
  endtask

  task automatic waitValid(input string tag, input int edgesSoFar, input int expected);
    int n = edgesSoFar;
    while (!valid && n < 200) begin
      tick();
      n++;
    end
    checkOutput({tag, "_latency"}, 128'(n), 128'(expected));
    checkOutput({tag, "_busy_done"}, 128'(busy), 128'(0));
  endtask

  task automatic runLaunch(input string tag, input logic [1:0] kl, input logic [255:0] key);
    applyStimulus(kl, key);
    checkOutput({tag, "_valid_accept"}, 128'(valid), 128'(0));
    checkOutput({tag, "_busy_accept"}, 128'(busy), 128'(1));
    waitValid(tag, 0, latencyOf(kl));
    modelExpand(kl, key);
    checkStore(tag);
  endtask

  function automatic logic [255:0] randKey();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [255:0] keyA, keyB;
    logic [1:0]   kl;

    reset  = 1'b1;
    start  = 1'b0;
    keyLen = 2'b00;
    keyIn  = '0;
`ifdef KEYSCHED_RDPORT_EN
    rkIdx  = 4'd0;
`endif
    buildSbox();
    checkOutput("model_sbox_00", 128'(tbSbox[8'h00]), 128'(8'h63));
    checkOutput("model_sbox_53", 128'(tbSbox[8'h53]), 128'(8'hed));
    tick();
    tick();
    reset = 1'b0;
    tick();
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_valid", 128'(valid), 128'(0));
    checkOutput("rst_err", 128'(err), 128'(0));
    for (int k = 0; k < 60; k++) expWords[k] = 32'h0;
    checkStore("rst");

    // Reserved key length from IDLE
    applyStimulus(2'b11, randKey());
    checkOutput("rsvd_idle_err", 128'(err), 128'(1));
    checkOutput("rsvd_idle_busy", 128'(busy), 128'(0));
    checkOutput("rsvd_idle_valid", 128'(valid), 128'(0));
    tick();
    checkOutput("rsvd_idle_err_drop", 128'(err), 128'(0));
    checkOutput("rsvd_idle_busy2", 128'(busy), 128'(0));

    keyA = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    runLaunch("aes128", 2'b00, keyA);
    checkOutput("aes128_rk10", dutRoundKey(10), 128'h13111d7fe3944a17f307a78b4d2b30c5);

`ifdef KEYSCHED_RDPORT_EN
    rkIdx = 4'd0;
    tick();
    checkOutput("rdport_rk0", rkOut, keyA[255:128]);
    rkIdx = 4'd10;
    tick();
    checkOutput("rdport_rk10", rkOut, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    rkIdx = 4'd11;
    tick();
    checkOutput("rdport_oor", rkOut, 128'h0);
    rkIdx = 4'd0;
`endif

    // Reserved key length from DONE leaves the schedule intact
    applyStimulus(2'b11, randKey());
    checkOutput("rsvd_done_err", 128'(err), 128'(1));
    checkOutput("rsvd_done_valid", 128'(valid), 128'(1));
    tick();
    checkOutput("rsvd_done_err_drop", 128'(err), 128'(0));
    checkStore("rsvd_done");

    keyA = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'hdeadbeefcafef00d};
    runLaunch("aes192", 2'b01, keyA);
    checkOutput("aes192_rk12", dutRoundKey(12), 128'ha4970a331a78dc09c418c271e3a41d5d);
    checkOutput("aes192_w52_55", dutRoundKey(13), 128'h0);
    checkOutput("aes192_w56_59", dutRoundKey(14), 128'h0);

    keyA = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    runLaunch("aes256", 2'b10, keyA);
    checkOutput("aes256_rk14", dutRoundKey(14), 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // start during a busy run is ignored
    keyA = randKey();
    keyB = randKey();
    applyStimulus(2'b00, keyA);
    repeat (9) tick();
    applyStimulus(2'b01, keyB);
    checkOutput("busystart_err", 128'(err), 128'(0));
    checkOutput("busystart_busy", 128'(busy), 128'(1));
    waitValid("busystart", 10, 41);
    modelExpand(2'b00, keyA);
    checkStore("busystart");

    // Asynchronous reset in the middle of EXPAND
    applyStimulus(2'b10, randKey());
    repeat (20) tick();
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_busy", 128'(busy), 128'(0));
    checkOutput("midrst_valid", 128'(valid), 128'(0));
    checkOutput("midrst_err", 128'(err), 128'(0));
    for (int k = 0; k < 60; k++) expWords[k] = 32'h0;
    checkStore("midrst");
    tick();
    reset = 1'b0;
    tick();
    keyA = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    runLaunch("postrst", 2'b00, keyA);
    checkOutput("postrst_w43", 128'(dutWord(43)), 128'(32'hb6630ca6));

    // Relaunch from DONE with a different key length
    runLaunch("relaunch256", 2'b10, randKey());
    runLaunch("relaunch192", 2'b01, randKey());

    for (int r = 0; r < 6; r++) begin
      kl = 2'($urandom_range(0, 2));
      runLaunch($sformatf("rand%0d", r), kl, randKey());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
